// File: rtl/game_sequencer.sv
// Frame-synchronous controller for the VGA dodge game: button conditioning, IDLE/PLAY/DEAD
// state machine, per-frame jump physics, enemy scrolling, collision and score.
module game_sequencer #(
    parameter int DATA_W      = 16,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_VIS_START = 35,
    parameter int SPRITE      = 60,
    parameter int PLAYER_X    = 200,
    parameter int GROUND_Y    = 400,
    parameter int ENEMY_Y     = 400,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int ENEMY_SPEED = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              button,
    output logic [DATA_W-1:0] x_player,
    output logic [DATA_W-1:0] y_player,
    output logic [DATA_W-1:0] x_enemy,
    output logic [DATA_W-1:0] y_enemy,
    output logic [1:0]        game_state,
    output logic              collision,
    output logic [DATA_W-1:0] score
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] XP_POS   = DATA_W'(PLAYER_X);
    localparam logic [DATA_W-1:0] YE_POS   = DATA_W'(ENEMY_Y);
    localparam logic [DATA_W-1:0] GROUND   = DATA_W'(GROUND_Y);
    localparam logic [DATA_W-1:0] TOP      = DATA_W'(V_VIS_START);
    localparam logic [DATA_W-1:0] SPR      = DATA_W'(SPRITE);
    localparam logic [DATA_W-1:0] SPD      = DATA_W'(ENEMY_SPEED);
    localparam logic [DATA_W-1:0] SPAWN_XE = DATA_W'(H_VIS_END - SPRITE);
    localparam logic [DATA_W-1:0] WRAP_X   = DATA_W'(H_VIS_START + ENEMY_SPEED);
    localparam logic signed [7:0] VEL_JUMP = 8'(-JUMP_V);
    localparam logic signed [7:0] VEL_G    = 8'(GRAVITY);

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        if (&v)
            return v;
        return v + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] clamp_y(input logic [DATA_W-1:0] y);
        if (y >= GROUND)
            return GROUND;
        if (y < TOP)
            return TOP;
        return y;
    endfunction

    function automatic logic overlap(input logic [DATA_W-1:0] xp, input logic [DATA_W-1:0] yp,
                                     input logic [DATA_W-1:0] xe, input logic [DATA_W-1:0] ye);
        return (xp < xe + SPR) && (xe < xp + SPR) && (yp < ye + SPR) && (ye < yp + SPR);
    endfunction

    // Button synchronizer and falling-edge detector
    logic btn_p0, btn_p1, btn_p2, press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_p0 <= 1'b1;
            btn_p1 <= 1'b1;
            btn_p2 <= 1'b1;
            press  <= 1'b0;
        end else begin
            btn_p0 <= button;
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
            press  <= btn_p2 & ~btn_p1;
        end
    end

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     y_q, y_d, xe_q, xe_d, score_q, score_d;
    logic signed [7:0]     vel_q, vel_d;
    logic                  coll_q, coll_d, jreq_q, jreq_d;

    logic                  on_ground;
    logic signed [7:0]     vel_eff, vel_nx, vel_upd;
    logic [DATA_W-1:0]     y_sum, y_upd, xe_upd, score_upd;
    logic                  hit;

    // Frame-update candidates, used only when a PLAY frame_start is taken
    always_comb begin
        on_ground = (y_q == GROUND) && (vel_q == 8'sd0);
        vel_eff   = (on_ground && (jreq_q || press)) ? VEL_JUMP : vel_q;
        vel_nx    = vel_eff + VEL_G;
        y_sum     = y_q + {{(DATA_W-8){vel_eff[7]}}, vel_eff};
        y_upd     = clamp_y(y_sum);
        vel_upd   = ((y_sum < GROUND) && (y_sum >= TOP)) ? vel_nx : 8'sd0;
        if (xe_q < WRAP_X) begin
            xe_upd    = SPAWN_XE;
            score_upd = sat_inc(score_q);
        end else begin
            xe_upd    = xe_q - SPD;
            score_upd = score_q;
        end
        hit = overlap(XP_POS, y_upd, xe_upd, YE_POS);
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        xe_d    = xe_q;
        score_d = score_q;
        coll_d  = coll_q;
        jreq_d  = jreq_q;
        unique case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_PLAY;
                    score_d = '0;
                end
            end
            S_PLAY: begin
                if (frame_start) begin
                    y_d     = y_upd;
                    vel_d   = vel_upd;
                    xe_d    = xe_upd;
                    score_d = score_upd;
                    jreq_d  = 1'b0;
                    if (hit) begin
                        state_d = S_DEAD;
                        coll_d  = 1'b1;
                    end
                end else if (press) begin
                    jreq_d = 1'b1;
                end
            end
            S_DEAD: begin
                if (press) begin
                    state_d = S_IDLE;
                    y_d     = GROUND;
                    vel_d   = 8'sd0;
                    xe_d    = SPAWN_XE;
                    jreq_d  = 1'b0;
                    coll_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Game state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            y_q     <= GROUND;
            vel_q   <= 8'sd0;
            xe_q    <= SPAWN_XE;
            score_q <= '0;
            coll_q  <= 1'b0;
            jreq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            xe_q    <= xe_d;
            score_q <= score_d;
            coll_q  <= coll_d;
            jreq_q  <= jreq_d;
        end
    end

    assign x_player   = XP_POS;
    assign y_player   = y_q;
    assign x_enemy    = xe_q;
    assign y_enemy    = YE_POS;
    assign game_state = state_q;
    assign collision  = coll_q;
    assign score      = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: two instances (enemy on the ground row and enemy at row 100)
// driven by shared inputs, checked against hand-derived frame-by-frame expectations.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        reset, frame_start, button;
    logic [15:0] xp0, yp0, xe0, ye0, sc0;
    logic [15:0] xp1, yp1, xe1, ye1, sc1;
    logic [1:0]  gs0, gs1;
    logic        col0, col1;

    always #5 clk = ~clk;

    game_sequencer u0 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .button(button),
        .x_player(xp0), .y_player(yp0), .x_enemy(xe0), .y_enemy(ye0),
        .game_state(gs0), .collision(col0), .score(sc0)
    );

    game_sequencer #(.ENEMY_Y(100)) u1 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .button(button),
        .x_player(xp1), .y_player(yp1), .x_enemy(xe1), .y_enemy(ye1),
        .game_state(gs1), .collision(col1), .score(sc1)
    );

    typedef struct {
        int frames;
        bit press;
        int yp0;
        int xe0;
        int st0;
        int col0;
        int sc0;
        int xe1;
        int st1;
        int sc1;
    } vec_t;

    vec_t vtab[11];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input int f, input bit p, input int y0, input int x0, input int s0,
                                input int c0, input int k0, input int x1, input int s1, input int k1);
        vec_t v;
        v.frames = f; v.press = p; v.yp0 = y0; v.xe0 = x0; v.st0 = s0;
        v.col0 = c0; v.sc0 = k0; v.xe1 = x1; v.st1 = s1; v.sc1 = k1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    task automatic do_press();
        @(negedge clk) button = 1'b0;
        repeat (5) @(negedge clk);
        button = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_row(input int i);
        vec_t e;
        exp_q.push_back(vtab[i]);
        if (vtab[i].press)
            do_press();
        repeat (vtab[i].frames) do_frame();
        e = exp_q.pop_front();
        check($sformatf("r%0d_y_player0", i), 32'(yp0), 32'(e.yp0));
        check($sformatf("r%0d_x_enemy0", i), 32'(xe0), 32'(e.xe0));
        check($sformatf("r%0d_state0", i), 32'(gs0), 32'(e.st0));
        check($sformatf("r%0d_collision0", i), 32'(col0), 32'(e.col0));
        check($sformatf("r%0d_score0", i), 32'(sc0), 32'(e.sc0));
        check($sformatf("r%0d_x_enemy1", i), 32'(xe1), 32'(e.xe1));
        check($sformatf("r%0d_state1", i), 32'(gs1), 32'(e.st1));
        check($sformatf("r%0d_score1", i), 32'(sc1), 32'(e.sc1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        //            frames press yp0  xe0 st0 c0 sc0  xe1 st1 sc1
        vtab[0]  = mk(10, 0, 400, 723, 0, 0, 0, 723, 0, 0);
        vtab[1]  = mk(1,  1, 388, 719, 1, 0, 0, 719, 1, 0);
        vtab[2]  = mk(11, 0, 322, 675, 1, 0, 0, 675, 1, 0);
        vtab[3]  = mk(12, 1, 388, 627, 1, 0, 0, 627, 1, 0);
        vtab[4]  = mk(1,  0, 400, 623, 1, 0, 0, 623, 1, 0);
        vtab[5]  = mk(1,  0, 400, 619, 1, 0, 0, 619, 1, 0);
        vtab[6]  = mk(89, 0, 400, 263, 1, 0, 0, 263, 1, 0);
        vtab[7]  = mk(1,  0, 400, 259, 2, 1, 0, 259, 1, 0);
        vtab[8]  = mk(28, 0, 400, 259, 2, 1, 0, 147, 1, 0);
        vtab[9]  = mk(1,  0, 400, 259, 2, 1, 0, 723, 1, 1);
        vtab[10] = mk(1,  0, 400, 259, 2, 1, 0, 719, 1, 1);

        reset = 1'b0;
        button = 1'b1;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(gs0), 32'd0);
        check("rst_x_player", 32'(xp0), 32'd200);
        check("rst_y_player", 32'(yp0), 32'd400);
        check("rst_x_enemy", 32'(xe0), 32'd723);
        check("rst_y_enemy0", 32'(ye0), 32'd400);
        check("rst_y_enemy1", 32'(ye1), 32'd100);
        check("rst_score", 32'(sc0), 32'd0);
        check("rst_collision", 32'(col0), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_row(0);

        // IDLE -> PLAY must be visible within 4 clocks of the pin falling edge
        @(negedge clk) button = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4 && gs0 == 2'd1)
                seen = 1'b1;
        end
        button = 1'b1;
        repeat (4) @(negedge clk);
        check("press_to_play_4clk", 32'(seen), 32'd1);
        check("play_x_enemy_before_frame", 32'(xe0), 32'd723);

        for (int i = 1; i < 11; i++)
            run_row(i);

        // DEAD -> IDLE reloads spawn; u1 (still in PLAY, on ground) arms a jump
        do_press();
        check("dead_exit_state", 32'(gs0), 32'd0);
        check("dead_exit_y_player", 32'(yp0), 32'd400);
        check("dead_exit_x_enemy", 32'(xe0), 32'd723);
        check("dead_exit_collision", 32'(col0), 32'd0);
        check("dead_exit_score", 32'(sc0), 32'd0);

        do_frame();
        check("idle_ignores_frame_x_enemy", 32'(xe0), 32'd723);
        check("idle_ignores_frame_state", 32'(gs0), 32'd0);
        check("u1_jump_y_player", 32'(yp1), 32'd388);
        check("u1_jump_x_enemy", 32'(xe1), 32'd715);

        // Asynchronous reset mid-jump, sampled before any further clock edge
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_state1", 32'(gs1), 32'd0);
        check("async_rst_y_player1", 32'(yp1), 32'd400);
        check("async_rst_score1", 32'(sc1), 32'd0);
        check("async_rst_x_enemy1", 32'(xe1), 32'd723);
        check("async_rst_collision1", 32'(col1), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        do_frame();
        check("post_rst_idle_x_enemy", 32'(xe0), 32'd723);

        do_press();
        check("replay_state", 32'(gs0), 32'd1);
        do_frame();
        check("idle_press_no_jump_y", 32'(yp0), 32'd400);
        check("idle_press_no_jump_xe", 32'(xe0), 32'd719);

        // Press pulse and frame_start land on the same clock
        @(negedge clk) button = 1'b0;
        repeat (3) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk) button = 1'b1;
        repeat (4) @(negedge clk);
        check("press_with_frame_y", 32'(yp0), 32'd388);
        check("press_with_frame_xe", 32'(xe0), 32'd715);
        check("press_with_frame_y1", 32'(yp1), 32'd388);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
